// File: rtl/ahb2apb_bridge_if.sv
// AHB-Lite slave port and APB3 master port of the AHB-to-APB bridge.
// The slave modport is the bridge's view; master is the environment's view.
interface ahb2apb_bridge_if #(
  parameter int APB_ADDR_WIDTH = 16,
  parameter int DATA_WIDTH     = 32
);
  logic                      HSEL;
  logic [31:0]               HADDR;
  logic [1:0]                HTRANS;
  logic                      HWRITE;
  logic [DATA_WIDTH-1:0]     HWDATA;
  logic                      HREADY;
  logic                      HREADY_OUT;
  logic [1:0]                HRESP;
  logic [DATA_WIDTH-1:0]     HRDATA;
  logic                      PSEL;
  logic                      PENABLE;
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic                      PWRITE;
  logic [DATA_WIDTH-1:0]     PWDATA;
  logic [DATA_WIDTH-1:0]     PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE,
    input  HWDATA, HREADY,
    input  PRDATA, PREADY, PSLVERR,
    output HREADY_OUT, HRESP, HRDATA,
    output PSEL, PENABLE, PADDR,
    output PWRITE, PWDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE,
    output HWDATA, HREADY,
    output PRDATA, PREADY, PSLVERR,
    input  HREADY_OUT, HRESP, HRDATA,
    input  PSEL, PENABLE, PADDR,
    input  PWRITE, PWDATA
  );
endinterface

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite to APB3 bridge, one transfer at a time, all outputs registered.
// Define AHB2APB_PSLVERR_EN to turn PSLVERR into a two-cycle AHB ERROR.
module ahb2apb_bridge #(
  parameter int APB_ADDR_WIDTH = 16,
  parameter int DATA_WIDTH     = 32
) (
  input  logic               HCLK,
  input  logic               HRESET,
  ahb2apb_bridge_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_e;

  localparam logic [1:0] OKAY  = 2'b00;
  localparam logic [1:0] ERROR = 2'b01;

  state_e                    state_q;
  logic                      hready_q;
  logic [1:0]                hresp_q;
  logic [DATA_WIDTH-1:0]     hrdata_q;
  logic                      psel_q;
  logic                      penable_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic                      pwrite_q;
  logic [DATA_WIDTH-1:0]     pwdata_q;

  logic accept;
  logic slverr;
  logic unused_in;

  assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;

`ifdef AHB2APB_PSLVERR_EN
  assign slverr    = bus.PSLVERR;
  assign unused_in = ^{bus.HADDR[31:APB_ADDR_WIDTH], bus.HTRANS[0]};
`else
  assign slverr    = 1'b0;
  assign unused_in = ^{bus.HADDR[31:APB_ADDR_WIDTH], bus.HTRANS[0],
                       bus.PSLVERR};
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= S_IDLE;
      hready_q  <= 1'b1;
      hresp_q   <= OKAY;
      hrdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR2: begin
          hresp_q  <= OKAY;
          hready_q <= ~accept;
          if (accept) begin
            paddr_q  <= bus.HADDR[APB_ADDR_WIDTH-1:0];
            pwrite_q <= bus.HWRITE;
            state_q  <= S_WDATA;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_WDATA: begin
          pwdata_q <= bus.HWDATA;
          psel_q   <= 1'b1;
          state_q  <= S_SETUP;
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (bus.PREADY) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            if (!pwrite_q)
              hrdata_q <= bus.PRDATA;
            // error keeps HREADY low one more cycle
            if (slverr) begin
              hresp_q <= ERROR;
              state_q <= S_ERR1;
            end else begin
              hready_q <= 1'b1;
              state_q  <= S_DONE;
            end
          end
        end
        S_ERR1: begin
          hready_q <= 1'b1;
          state_q  <= S_ERR2;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.HREADY_OUT = hready_q;
  assign bus.HRESP      = hresp_q;
  assign bus.HRDATA     = hrdata_q;
  assign bus.PSEL       = psel_q;
  assign bus.PENABLE    = penable_q;
  assign bus.PADDR      = paddr_q;
  assign bus.PWRITE     = pwrite_q;
  assign bus.PWDATA     = pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Bench for ahb2apb_bridge: transfer-age model plus directed checks.
// Global HREADY and PREADY are generated from the model, not the DUT.
`timescale 1ns/1ps
module tb_ahb2apb_bridge;
  localparam int AW = 16;
  localparam int DW = 32;
`ifdef AHB2APB_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic HCLK   = 1'b0;
  logic HRESET = 1'b1;

  ahb2apb_bridge_if #(.APB_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ahb2apb_bridge #(.APB_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // age: 0 free, 1 data phase, 2 setup, >=3 access; errc: 2/1 error tail
  int            age = 0;
  int            errc = 0;
  int            wait_left = 0;
  int            wait_req = 0;
  logic          hrdy_q = 1'b1;
  logic [AW-1:0] m_addr = '0;
  logic          m_wr = 1'b0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;

  assign bus.HREADY = hrdy_q;
  assign bus.PREADY = (wait_left == 0);

  always @(posedge HCLK) begin
    if (HRESET) begin
      age = 0; errc = 0; wait_left <= 0;
      m_addr = '0; m_wr = 1'b0; m_wdata = '0; m_rdata = '0;
    end else if (age == 0) begin
      if (errc == 2) errc = 1;
      else begin
        errc = 0;
        if (bus.HSEL && bus.HTRANS[1]) begin
          age = 1;
          m_addr = bus.HADDR[AW-1:0];
          m_wr = bus.HWRITE;
          wait_left <= wait_req;
        end
      end
    end else if (age == 1) begin
      m_wdata = bus.HWDATA; age = 2;
    end else if (age == 2) begin
      age = 3;
    end else if (bus.PREADY) begin
      if (!m_wr) m_rdata = bus.PRDATA;
      errc = (ERR_EN && bus.PSLVERR) ? 2 : 0;
      age = 0;
    end else begin
      wait_left <= wait_left - 1;
      age = age + 1;
    end
    hrdy_q <= (age == 0) && (errc != 2);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge HCLK) begin
    if (cmp_en) begin
      #1;
      chk("m_hready", bus.HREADY_OUT, (age == 0) && (errc != 2));
      chk("m_hresp", bus.HRESP, (errc != 0) ? 2'b01 : 2'b00);
      chk("m_psel", bus.PSEL, age >= 2);
      chk("m_penable", bus.PENABLE, age >= 3);
      chk("m_hrdata", bus.HRDATA, m_rdata);
      chk("m_paddr", bus.PADDR, m_addr);
      chk("m_pwrite", bus.PWRITE, m_wr);
      chk("m_pwdata", bus.PWDATA, m_wdata);
    end
  end

  task automatic step();
    @(posedge HCLK);
    #2;
  endtask

  task automatic issue(input logic [31:0] a, input logic w,
                       input logic [DW-1:0] rd, input int waits,
                       input logic err);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10;
    bus.HADDR = a; bus.HWRITE = w;
    bus.PRDATA = rd; bus.PSLVERR = err;
    wait_req = waits;
  endtask

  task automatic release_bus(input logic [DW-1:0] wd);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = wd;
  endtask

  task automatic wait_free();
    int n = 0;
    while (!((age == 0) && (errc != 2)) && n < 60) begin
      step(); n++;
    end
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL timeout waiting for bridge free t=%0t", $time);
    end
  endtask

  typedef struct {
    logic [31:0] a; logic w; logic [31:0] d; int waits; logic err;
  } vec_t;
  vec_t vecs[4] = '{
    '{32'h7000_0100, 1'b1, 32'h0102_0304, 3, 1'b0},
    '{32'h7000_FFFC, 1'b0, 32'hF0E1_D2C3, 1, 1'b0},
    '{32'h7000_0200, 1'b1, 32'h5555_AAAA, 0, 1'b1},
    '{32'h7000_0204, 1'b0, 32'h8765_4321, 2, 1'b1}
  };

  initial begin
    bus.HSEL = 0; bus.HADDR = 0; bus.HTRANS = 0; bus.HWRITE = 0;
    bus.HWDATA = 0; bus.PRDATA = 0; bus.PSLVERR = 0;
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_hready", bus.HREADY_OUT, 1);
    chk("rst_hresp", bus.HRESP, 0);
    chk("rst_psel", bus.PSEL, 0);
    chk("rst_penable", bus.PENABLE, 0);
    chk("rst_hrdata", bus.HRDATA, 0);
    @(negedge HCLK);
    HRESET = 1'b0;
    cmp_en = 1'b1;
    step();

    // write, zero-wait APB
    issue(32'h7000_0010, 1'b1, 32'h0, 0, 1'b0);
    step(); release_bus(32'hDEAD_BEEF);
    chk("wr_t1_hready", bus.HREADY_OUT, 0);
    chk("wr_t1_psel", bus.PSEL, 0);
    step();
    chk("wr_t2_psel", bus.PSEL, 1);
    chk("wr_t2_penable", bus.PENABLE, 0);
    chk("wr_t2_paddr", bus.PADDR, 16'h0010);
    chk("wr_t2_pwrite", bus.PWRITE, 1);
    chk("wr_t2_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
    step();
    chk("wr_t3_penable", bus.PENABLE, 1);
    chk("wr_t3_hready", bus.HREADY_OUT, 0);
    step();
    chk("wr_t4_hready", bus.HREADY_OUT, 1);
    chk("wr_t4_psel", bus.PSEL, 0);

    // back-to-back read accepted in DONE
    issue(32'h7000_0020, 1'b0, 32'hAAAA_5555, 0, 1'b0);
    step(); release_bus(32'h0);
    chk("b2b_t1_hready", bus.HREADY_OUT, 0);
    chk("b2b_t1_psel", bus.PSEL, 0);
    step();
    chk("b2b_t2_psel", bus.PSEL, 1);
    chk("b2b_t2_penable", bus.PENABLE, 0);
    chk("b2b_t2_paddr", bus.PADDR, 16'h0020);
    step(); step();
    chk("b2b_t4_hready", bus.HREADY_OUT, 1);
    chk("b2b_t4_hrdata", bus.HRDATA, 32'hAAAA_5555);
    step();

    // read with two APB wait states
    issue(32'h7000_0004, 1'b0, 32'h1234_5678, 2, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) release_bus(32'h0);
      chk("rdw_hready_low", bus.HREADY_OUT, 0);
    end
    step();
    chk("rdw_t6_hready", bus.HREADY_OUT, 1);
    chk("rdw_t6_hrdata", bus.HRDATA, 32'h1234_5678);
    step();

    // PSLVERR response
    issue(32'h7000_0008, 1'b0, 32'hCAFE_F00D, 0, 1'b1);
    step(); release_bus(32'h0);
    step(); step(); step();
    chk("err_t4_hresp", bus.HRESP, ERR_EN ? 2'b01 : 2'b00);
    chk("err_t4_hready", bus.HREADY_OUT, ERR_EN ? 1'b0 : 1'b1);
    chk("err_t4_hrdata", bus.HRDATA, 32'hCAFE_F00D);
    step();
    chk("err_t5_hresp", bus.HRESP, ERR_EN ? 2'b01 : 2'b00);
    chk("err_t5_hready", bus.HREADY_OUT, 1);
    step();
    chk("err_t6_hresp", bus.HRESP, 0);
    bus.PSLVERR = 1'b0;

    // IDLE and BUSY with HSEL high
    bus.HSEL = 1'b1; bus.HTRANS = 2'b00;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) bus.HTRANS = 2'b01;
      step();
      chk("idle_psel", bus.PSEL, 0);
      chk("idle_hready", bus.HREADY_OUT, 1);
    end
    release_bus(32'h0);

    // reset during ACCESS
    issue(32'h7000_0030, 1'b1, 32'h0, 5, 1'b0);
    step(); release_bus(32'h1111_2222);
    step(); step();
    chk("rst_mid_penable", bus.PENABLE, 1);
    HRESET = 1'b1;
    step();
    chk("rst_mid_psel", bus.PSEL, 0);
    chk("rst_mid_penable0", bus.PENABLE, 0);
    chk("rst_mid_hready", bus.HREADY_OUT, 1);
    chk("rst_mid_paddr", bus.PADDR, 0);
    HRESET = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      issue(vecs[i].a, vecs[i].w, vecs[i].d, vecs[i].waits, vecs[i].err);
      step();
      release_bus(~vecs[i].d);
      wait_free();
      bus.PSLVERR = 1'b0;
      step();
    end

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
